dot_seq_ctrl: RTL and testbench
===============================

# dot_seq_ctrl

Avalon-MM controller that sequences the single-precision floating multiplier and floating add/sub units to compute a full vector dot product without per-element host intervention. The host pushes operand pairs into an internal FIFO, programs the vector length and issues start. A state machine then streams the pairs through the multiplier and accumulates the products through the adder. The result and status are read back over the same Avalon slave.

## Interface
- `FIFO_DEPTH`, default 8: operand-pair FIFO depth; power of two, 2..64.
- `LEN_W`, default 16: width of the length and element counters.

Ports:
- `clk`  in  1  clock from the Avalon bus.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `writedata`  in  32  write data.
- `write`  in  1  write strobe.
- `read`  in  1  read strobe.
- `readdata`  out  32  registered read data.
- `mul_a`, `mul_b`  out  32  multiplier operands; these are the `op_a`/`op_b` registers.
- `mul_out`  in  32  multiplier result (combinational).
- `add_a`, `add_b`  out  32  adder operands; these are the `prod_q`/`acc_q` registers.
- `add_out`  in  32  adder result (combinational).

## Operation
Write map:
- 0 = A staging register.
- 1 = B: pushes {A, B} into the FIFO.
- 2 = LEN.
- 3 = CTRL: bit0 start, bit1 clear.

Read map:
- 0 = `acc_q`.
- 1 = status: {[31:16] elements done, [15:8] FIFO count, bit4 busy, bit3 done, bit2 ovf, bit1 full, bit0 empty}.
- 2 = LEN.
- 3 = A staging register.

Bus rules:
- `read` has priority; a `write` in the same cycle is ignored.
- Reads have no side effects.

FSM states: IDLE, FETCH, MUL, ACC, DONE.
- IDLE, on start: `acc_q` = 0, count = 0, done = 0. Go to FETCH, or directly to DONE if LEN = 0.
- FETCH: if the FIFO is empty, stall in FETCH. Otherwise pop the pair into `op_a`/`op_b` and go to MUL.
- MUL: `prod_q` <= `mul_out`; go to ACC.
- ACC: `acc_q` <= `add_out`; count++. Go to DONE if count+1 == LEN, else FETCH.
- DONE: set done and return to IDLE next cycle. `acc_q` holds until the next start or clear.

Boundary rules:
- Push while full: pair dropped, sticky ovf set. Ovf clears only on clear or reset.
- Push and pop in the same cycle are both honoured; count is unchanged.
- Start while busy (not IDLE): ignored. LEN writes while busy: ignored.
- Clear (any state): FIFO flushed; `acc_q`, `prod_q`, `op_a`, `op_b` and count zeroed; done and ovf cleared; go to IDLE. Clear beats start if both bits are written together.
- Leftover FIFO entries after DONE remain queued for the next start.
- Reset asserted mid-operation: all registers and outputs go to 0 immediately; FSM goes to IDLE; FIFO is emptied.

## Timing
- All outputs are 0 during reset. Status reads 0x0000_0001 after reset (empty only).
- `readdata` is valid on the edge following `read` (1-cycle latency).
- Each element takes 3 cycles (FETCH, MUL, ACC) when the FIFO is non-empty.
- Done rises 3·LEN + 1 cycles after the start write edge when the FIFO is pre-filled.
- LEN = 0: done after 1 cycle.
- The multiplier and adder paths are each exactly one register-to-register combinational hop.

## Configuration
- `DOT_SEQ_ZERO_SKIP_EN` defined: in FETCH, a pair where either operand has bits[30:0] == 0 is popped and counted in that single cycle, and the MUL and ACC states are skipped. `acc_q` is unchanged by that pair. If that pair is the last element (count+1 == LEN), go to DONE.
- `DOT_SEQ_ZERO_SKIP_EN` undefined: every pair takes the full 3 cycles. The numeric result is identical apart from the sign of zero.

## Test plan
- Push [1.0, 3.0] and [2.0, 4.0] (0x3F800000/0x40400000, 0x40000000/0x40800000); LEN = 2; start. Required: done after 7 cycles; read 0 returns 0x41300000 (11.0); status elements done = 2.
- LEN = 0; start. Required: done next cycle; result 0x00000000; FIFO untouched.
- Push 9 pairs with `FIFO_DEPTH` = 8. Required: full = 1, ovf = 1, FIFO count = 8. Clear, then status reads 0x0000_0001.
- LEN = 3 with only 1 pair queued; start. Required: FSM stalls in FETCH with busy = 1. Push 2 more pairs, then done with the correct sum.
- Assert reset during ACC of element 2. Required: `readdata`, `mul_a`/`mul_b`, `add_a`/`add_b` = 0 asynchronously; status 0x0000_0001 after release.
- Macro on: pairs [0.0, 5.0], [2.0, 2.0], LEN = 2. Required: done after 5 cycles; result 0x40800000. Macro off: done after 7 cycles, same result.

Source files
------------

// File: rtl/dot_seq_ctrl.sv
// dot_seq_ctrl: Avalon-MM sequencer that streams queued operand pairs through an
// external single-precision multiplier and adder to form a vector dot product.
// Optional feature macro: DOT_SEQ_ZERO_SKIP_EN (pairs with a zero operand are
// consumed in one FETCH cycle without visiting MUL/ACC).
module dot_seq_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic [31:0] writedata,
   input  logic        write,
   input  logic        read,
   output logic [31:0] readdata,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_out,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, FETCH, MUL, ACC, DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        aStage_q;
   logic [LEN_W-1:0]   len_q;
   logic [31:0]        opA_q, opA_d, opB_q, opB_d;
   logic [31:0]        prod_q, prod_d, acc_q, acc_d;
   logic [LEN_W-1:0]   elemCnt_q, elemCnt_d;
   logic               done_q, done_d;
   logic               ovf_q;
   logic [31:0]        readdata_q;
   logic [63:0]        fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]   fifoCnt_q;

   logic               wrEn, pushReq, pushOk, startReq, clearReq, lenWr;
   logic               fifoEmpty, fifoFull, pop, busy, lastElem;
   logic [31:0]        headA, headB, statusWord, readMux;
   logic [LEN_W-1:0]   elemInc;

   // Bus decode: a read in the same cycle suppresses any write.
   always_comb begin
      wrEn      = write & ~read;
      pushReq   = wrEn && (address == 2'd1);
      clearReq  = wrEn && (address == 2'd3) && writedata[1];
      startReq  = wrEn && (address == 2'd3) && writedata[0];
      lenWr     = wrEn && (address == 2'd2) && (state_q == IDLE);
      fifoEmpty = (fifoCnt_q == '0);
      fifoFull  = (fifoCnt_q == CNT_W'(FIFO_DEPTH));
      pushOk    = pushReq && !fifoFull;
      headA     = fifoMem[rdPtr_q][63:32];
      headB     = fifoMem[rdPtr_q][31:0];
      busy      = (state_q != IDLE);
      elemInc   = elemCnt_q + LEN_W'(1);
      lastElem  = (elemInc == len_q);
   end

   // Sequencer next state and datapath loads; clear overrides everything.
   always_comb begin
      state_d   = state_q;
      opA_d     = opA_q;
      opB_d     = opB_q;
      prod_d    = prod_q;
      acc_d     = acc_q;
      elemCnt_d = elemCnt_q;
      done_d    = done_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (startReq) begin
               acc_d     = '0;
               elemCnt_d = '0;
               done_d    = 1'b0;
               state_d   = (len_q == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (!fifoEmpty) begin
               pop   = 1'b1;
               opA_d = headA;
               opB_d = headB;
`ifdef DOT_SEQ_ZERO_SKIP_EN
               if ((headA[30:0] == 31'd0) || (headB[30:0] == 31'd0)) begin
                  elemCnt_d = elemInc;
                  state_d   = lastElem ? DONE : FETCH;
               end else begin
                  state_d = MUL;
               end
`else
               state_d = MUL;
`endif
            end
         end
         MUL: begin
            prod_d  = mul_out;
            state_d = ACC;
         end
         ACC: begin
            acc_d     = add_out;
            elemCnt_d = elemInc;
            state_d   = lastElem ? DONE : FETCH;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clearReq) begin
         state_d   = IDLE;
         opA_d     = '0;
         opB_d     = '0;
         prod_d    = '0;
         acc_d     = '0;
         elemCnt_d = '0;
         done_d    = 1'b0;
         pop       = 1'b0;
      end
   end

   // Status word and read-back multiplexer.
   always_comb begin
      statusWord = {16'(elemCnt_q), 8'(fifoCnt_q), 3'b000, busy, done_q, ovf_q,
                    fifoFull, fifoEmpty};
      case (address)
         2'd0:    readMux = acc_q;
         2'd1:    readMux = statusWord;
         2'd2:    readMux = 32'(len_q);
         default: readMux = aStage_q;
      endcase
   end

   // All control and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         aStage_q   <= '0;
         len_q      <= '0;
         opA_q      <= '0;
         opB_q      <= '0;
         prod_q     <= '0;
         acc_q      <= '0;
         elemCnt_q  <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         readdata_q <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         fifoCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         opA_q     <= opA_d;
         opB_q     <= opB_d;
         prod_q    <= prod_d;
         acc_q     <= acc_d;
         elemCnt_q <= elemCnt_d;
         done_q    <= done_d;
         if (clearReq)
            ovf_q <= 1'b0;
         else if (pushReq && fifoFull)
            ovf_q <= 1'b1;
         if (wrEn && (address == 2'd0))
            aStage_q <= writedata;
         if (lenWr)
            len_q <= writedata[LEN_W-1:0];
         if (read)
            readdata_q <= readMux;
         if (clearReq) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            fifoCnt_q <= '0;
         end else begin
            if (pushOk)
               wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)
               rdPtr_q <= rdPtr_q + PTR_W'(1);
            if (pushOk && !pop)
               fifoCnt_q <= fifoCnt_q + CNT_W'(1);
            else if (pop && !pushOk)
               fifoCnt_q <= fifoCnt_q - CNT_W'(1);
         end
      end
   end

   // Pair storage; emptiness is tracked by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (pushOk)
         fifoMem[wrPtr_q] <= {aStage_q, writedata};
   end

   assign readdata = readdata_q;
   assign mul_a    = opA_q;
   assign mul_b    = opB_q;
   assign add_a    = prod_q;
   assign add_b    = acc_q;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// tb_dot_seq_ctrl: directed and randomized checks of dot_seq_ctrl against a
// queue-based dot-product model. Latency expectations follow DOT_SEQ_ZERO_SKIP_EN.
module tb_dot_seq_ctrl;

   localparam int DEPTH = 8;

   logic        clk, reset;
   logic [1:0]  address;
   logic [31:0] writedata;
   logic        write, read;
   logic [31:0] readdata, mul_a, mul_b, mul_out, add_a, add_b, add_out;

   int compCnt = 0;
   int failCnt = 0;

   logic [31:0] qA[$];
   logic [31:0] qB[$];
   int          modelElems;
   logic        modelDone, modelOvf;

   dot_seq_ctrl #(.FIFO_DEPTH(DEPTH), .LEN_W(16)) dut (
      .clk(clk), .reset(reset), .address(address), .writedata(writedata),
      .write(write), .read(read), .readdata(readdata),
      .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
      .add_a(add_a), .add_b(add_b), .add_out(add_out)
   );

   // Free-running bus clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-precision to real, valid for zero and normal numbers.
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      logic [10:0] e;
      if (f[30:0] == 31'd0) begin
         d = {f[31], 63'd0};
      end else begin
         e = {3'b000, f[30:23]} + 11'd896;
         d = {f[31], e, f[22:0], 29'd0};
      end
      return $bitstoreal(d);
   endfunction

   // Real to single precision; exact for the small integers used here.
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (r == 0.0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] intToFloat(input int v);
      return r2f(real'(v));
   endfunction

   // Behavioural floating-point units attached to the controller.
   always_comb mul_out = r2f(f2r(mul_a) * f2r(mul_b));
   always_comb add_out = r2f(f2r(add_a) + f2r(add_b));

   // Watchdog so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] expStatus(input logic busyExp);
      int sz;
      sz = qA.size();
      return {16'(modelElems), 8'(sz), 3'b000, busyExp, modelDone, modelOvf,
              (sz == DEPTH), (sz == 0)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compCnt++;
      assert (observed === expected) else begin
         failCnt++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(posedge clk);
      #1;
      write     = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      address = a;
      read    = 1'b1;
      @(posedge clk);
      #1;
      read    = 1'b0;
      d       = readdata;
   endtask

   task automatic pushPair(input logic [31:0] a, input logic [31:0] b);
      applyStimulus(2'd0, a);
      applyStimulus(2'd1, b);
      if (qA.size() < DEPTH) begin
         qA.push_back(a);
         qB.push_back(b);
      end else begin
         modelOvf = 1'b1;
      end
   endtask

   task automatic clearAll();
      applyStimulus(2'd3, 32'h2);
      qA.delete();
      qB.delete();
      modelElems = 0;
      modelDone  = 1'b0;
      modelOvf   = 1'b0;
   endtask

   // Polls status continuously; lat is cycles from the start edge to done.
   task automatic waitDone(output int lat);
      lat     = -1;
      address = 2'd1;
      read    = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (readdata[3] === 1'b1) begin
            lat = k - 1;
            break;
         end
      end
      read = 1'b0;
   endtask

   task automatic runDot(input int len, input string tag);
      int          expLat, lat;
      real         sum;
      logic [31:0] a, b, obs;
      sum    = 0.0;
      expLat = 1;
      for (int i = 0; i < len; i++) begin
         a = qA.pop_front();
         b = qB.pop_front();
         sum += f2r(a) * f2r(b);
`ifdef DOT_SEQ_ZERO_SKIP_EN
         expLat += ((a[30:0] == 31'd0) || (b[30:0] == 31'd0)) ? 1 : 3;
`else
         expLat += 3;
`endif
      end
      modelElems = len;
      modelDone  = 1'b1;
      applyStimulus(2'd2, 32'(len));
      applyStimulus(2'd3, 32'h1);
      waitDone(lat);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
      busRead(2'd0, obs);
      checkOutput({tag, "_acc"}, obs, r2f(sum));
      busRead(2'd1, obs);
      checkOutput({tag, "_status"}, obs, expStatus(1'b0));
      busRead(2'd2, obs);
      checkOutput({tag, "_len"}, obs, 32'(len));
   endtask

   // Directed sequence followed by randomized dot products and a mid-run reset.
   initial begin
      logic [31:0] obs;
      logic [31:0] pa [3];
      logic [31:0] pb [3];
      real         sum;
      int          lat, n, len;

      reset = 1'b1; address = '0; writedata = '0; write = 1'b0; read = 1'b0;
      modelElems = 0; modelDone = 1'b0; modelOvf = 1'b0;
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_readdata", readdata, 32'h0);
      checkOutput("rst_mul_a", mul_a, 32'h0);
      checkOutput("rst_add_b", add_b, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      busRead(2'd1, obs);
      checkOutput("rst_status", obs, 32'h0000_0001);
      busRead(2'd0, obs);
      checkOutput("rst_acc", obs, 32'h0);

      $display("[TB] two-element dot product");
      pushPair(32'h3F800000, 32'h40400000);
      pushPair(32'h40000000, 32'h40800000);
      runDot(2, "tp1");
      busRead(2'd0, obs);
      checkOutput("tp1_eleven", obs, 32'h41300000);

      $display("[TB] zero length");
      pushPair(intToFloat(2), intToFloat(3));
      runDot(0, "len0");
      clearAll();

      $display("[TB] stall on empty FIFO");
      pa[0] = intToFloat(2); pb[0] = intToFloat(3);
      pa[1] = intToFloat(4); pb[1] = intToFloat(1);
      pa[2] = intToFloat(5); pb[2] = intToFloat(2);
      pushPair(pa[0], pb[0]);
      applyStimulus(2'd2, 32'd3);
      applyStimulus(2'd3, 32'h1);
      void'(qA.pop_front()); void'(qB.pop_front());
      repeat (20) @(posedge clk);
      #1;
      modelElems = 1;
      busRead(2'd1, obs);
      checkOutput("stall_status", obs, expStatus(1'b1));
      applyStimulus(2'd2, 32'd5);
      applyStimulus(2'd3, 32'h1);
      busRead(2'd2, obs);
      checkOutput("stall_len_locked", obs, 32'd3);
      busRead(2'd1, obs);
      checkOutput("stall_restart_ignored", obs, expStatus(1'b1));
      pushPair(pa[1], pb[1]);
      void'(qA.pop_front()); void'(qB.pop_front());
      pushPair(pa[2], pb[2]);
      void'(qA.pop_front()); void'(qB.pop_front());
      modelElems = 3;
      modelDone  = 1'b1;
      waitDone(lat);
      checkOutput("stall_finished", 32'(lat >= 0), 32'd1);
      sum = 0.0;
      for (int i = 0; i < 3; i++) sum += f2r(pa[i]) * f2r(pb[i]);
      busRead(2'd0, obs);
      checkOutput("stall_acc", obs, r2f(sum));
      busRead(2'd1, obs);
      checkOutput("stall_final_status", obs, expStatus(1'b0));

      $display("[TB] overflow and clear");
      clearAll();
      for (int i = 0; i < 9; i++) pushPair(intToFloat(i + 1), intToFloat(1));
      busRead(2'd1, obs);
      checkOutput("ovf_status", obs, expStatus(1'b0));
      checkOutput("ovf_status_const", obs, 32'h0000_0806);
      clearAll();
      busRead(2'd1, obs);
      checkOutput("clear_status", obs, 32'h0000_0001);

      $display("[TB] zero operand pair");
      pushPair(32'h00000000, 32'h40A00000);
      pushPair(32'h40000000, 32'h40000000);
      runDot(2, "zero");
      busRead(2'd0, obs);
      checkOutput("zero_four", obs, 32'h40800000);

      $display("[TB] randomized dot products");
      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(1, 4));
         if (qA.size() + n > DEPTH) clearAll();
         for (int j = 0; j < n; j++)
            pushPair(intToFloat(int'($urandom_range(0, 6))),
                     intToFloat(int'($urandom_range(0, 6))));
         len = int'($urandom_range(0, qA.size()));
         runDot(len, "rand");
      end

      $display("[TB] reset during accumulate");
      clearAll();
      pa[0] = intToFloat(2); pb[0] = intToFloat(3);
      pa[1] = intToFloat(4); pb[1] = intToFloat(5);
      pa[2] = intToFloat(1); pb[2] = intToFloat(1);
      for (int i = 0; i < 3; i++) pushPair(pa[i], pb[i]);
      applyStimulus(2'd2, 32'd3);
      applyStimulus(2'd3, 32'h1);
      address = 2'd3;
      read    = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("pre_rst_mul_a", mul_a, pa[1]);
      checkOutput("pre_rst_add_a", add_a, r2f(f2r(pa[1]) * f2r(pb[1])));
      checkOutput("pre_rst_add_b", add_b, r2f(f2r(pa[0]) * f2r(pb[0])));
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_readdata", readdata, 32'h0);
      checkOutput("mid_rst_mul_a", mul_a, 32'h0);
      checkOutput("mid_rst_mul_b", mul_b, 32'h0);
      checkOutput("mid_rst_add_a", add_a, 32'h0);
      checkOutput("mid_rst_add_b", add_b, 32'h0);
      read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      qA.delete(); qB.delete();
      modelElems = 0; modelDone = 1'b0; modelOvf = 1'b0;
      busRead(2'd1, obs);
      checkOutput("post_rst_status", obs, 32'h0000_0001);
      busRead(2'd3, obs);
      checkOutput("post_rst_astage", obs, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
      $finish;
   end

endmodule
